// File: rtl/turn_signal_pkg.sv
// ---------------------------------------------------------------------------
// turn_signal_pkg
// Shared constants and helpers for the turn-signal input conditioner.
//   SYNC_STAGES_DEF     : default synchronizer depth (two flops minimum).
//   DEBOUNCE_CYCLES_DEF : default number of consecutive disagreeing cycles
//                         needed before a debounced level flips.
//   REPEAT_CYCLES_DEF   : default auto-repeat period (TURN_REPEAT_EN builds).
//   cnt_width(n)        : bits needed to hold a count from 0 up to n.
// ---------------------------------------------------------------------------
package turn_signal_pkg;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int REPEAT_CYCLES_DEF   = 4;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/turn_signal_conditioner_debouncer.sv
// ---------------------------------------------------------------------------
// switch_debouncer
// One channel of the turn-lever conditioner: a SYNC_STAGES-deep synchronizer
// followed by a saturating debounce counter that owns the debounced level.
//
// Ports:
//   clock   in  system clock, rising edge
//   reset_n in  asynchronous active-low reset
//   sw      in  raw, asynchronous, possibly bouncing lever contact
//   level   out debounced lever level (registered)
//   flip    out high in the cycle whose closing edge toggles `level`;
//               the parent combines it with `level` to tell rise from fall
// ---------------------------------------------------------------------------
module switch_debouncer
  import turn_signal_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic sw,
  output logic level,
  output logic flip
);

  localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   sync_in;

  assign sync_in = sync_q[SYNC_STAGES-1];

  // NOTE: every signal driven here gets a value before any branch, so the
  // block stays purely combinational and no latch can be inferred.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], sw};
    cnt_d   = '0;
    level_d = level_q;
    flip    = 1'b0;
    if (sync_in != level_q) begin
      // The edge that would bring the count to DEBOUNCE_CYCLES flips the
      // level instead and restarts the count, so the counter never wraps.
      if (cnt_q == LAST) begin
        level_d = sync_in;
        flip    = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of the others, exactly like the hardware chain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/turn_signal_conditioner.sv
// ---------------------------------------------------------------------------
// turn_signal_conditioner
// Input stage ahead of the tail-light sequencer. Synchronizes and debounces
// the left/right turn-lever contacts and emits one-cycle request pulses on
// each debounced press. `left` and `right` are never high together; when
// both would pulse in the same cycle, left wins and the right request is
// dropped.
//
// Optional feature (macro TURN_REPEAT_EN): while a debounced level stays
// high and the levels do not conflict, the channel re-pulses every
// REPEAT_CYCLES cycles after its initial pulse. Without the macro exactly
// one pulse is produced per press and no repeat counters exist.
//
// Ports:
//   clock       in  system clock, rising edge
//   reset_n     in  asynchronous active-low reset
//   left_sw     in  raw left lever contact
//   right_sw    in  raw right lever contact
//   left        out one-cycle left request pulse (registered)
//   right       out one-cycle right request pulse (registered)
//   left_level  out debounced left level
//   right_level out debounced right level
//   conflict    out both debounced levels high
// ---------------------------------------------------------------------------
module turn_signal_conditioner
  import turn_signal_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`ifdef TURN_REPEAT_EN
  ,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
`endif
) (
  input  logic clock,
  input  logic reset_n,
  input  logic left_sw,
  input  logic right_sw,
  output logic left,
  output logic right,
  output logic left_level,
  output logic right_level,
  output logic conflict
);

  logic l_level, l_flip, r_level, r_flip;
  logic l_rise, r_rise;
  logic left_req, right_req;
  logic left_q, left_d, right_q, right_d;

  switch_debouncer #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_left_db (
    .clock  (clock),
    .reset_n(reset_n),
    .sw     (left_sw),
    .level  (l_level),
    .flip   (l_flip)
  );

  switch_debouncer #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_right_db (
    .clock  (clock),
    .reset_n(reset_n),
    .sw     (right_sw),
    .level  (r_level),
    .flip   (r_flip)
  );

  // A flip while the level is low is a 0->1 transition; falls never pulse.
  assign l_rise = l_flip & ~l_level;
  assign r_rise = r_flip & ~r_level;

`ifdef TURN_REPEAT_EN
  localparam int            RW    = cnt_width(REPEAT_CYCLES);
  localparam logic [RW-1:0] RLAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] l_rep_q, l_rep_d, r_rep_q, r_rep_d;
  logic          l_rep_pulse, r_rep_pulse;
  logic          l_hold, r_hold, conflict_next;

  // A channel keeps repeating only if its level is high now and is not
  // falling on this edge, and the levels will not be in conflict after it.
  // Using the post-edge view suppresses a repeat on the very edge where the
  // level drops or the conflict begins.
  assign l_hold        = l_level & ~l_flip;
  assign r_hold        = r_level & ~r_flip;
  assign conflict_next = (l_level ^ l_flip) & (r_level ^ r_flip);

  always_comb begin
    l_rep_d     = '0;
    r_rep_d     = '0;
    l_rep_pulse = 1'b0;
    r_rep_pulse = 1'b0;
    if (l_hold && !conflict_next) begin
      if (l_rep_q == RLAST) l_rep_pulse = 1'b1;
      else                  l_rep_d     = l_rep_q + 1'b1;
    end
    if (r_hold && !conflict_next) begin
      if (r_rep_q == RLAST) r_rep_pulse = 1'b1;
      else                  r_rep_d     = r_rep_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      l_rep_q <= '0;
      r_rep_q <= '0;
    end else begin
      l_rep_q <= l_rep_d;
      r_rep_q <= r_rep_d;
    end
  end

  assign left_req  = l_rise | l_rep_pulse;
  assign right_req = r_rise | r_rep_pulse;
`else
  assign left_req  = l_rise;
  assign right_req = r_rise;
`endif

  // Left has priority; a colliding right request is dropped, not deferred.
  always_comb begin
    left_d  = left_req;
    right_d = right_req & ~left_req;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else begin
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  assign left        = left_q;
  assign right       = right_q;
  assign left_level  = l_level;
  assign right_level = r_level;
  assign conflict    = l_level & r_level;

endmodule
